fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
Read-domain drain stage that sits directly downstream of the async FIFO top. It pops 16-bit words from the FIFO read port and accounts for the FIFO's one-cycle registered read latency. Words are held in a 2-entry skid buffer and presented as a valid/ready stream. Fixed-length packet framing is added (m_last every PKT_LEN beats), and completed packets are counted.

Parameters:
DATA_W, 16, word width; matches FIFO D_out.
PKT_LEN, 8, beats per packet; legal range 1..256.
CNT_W, 8, width of the completed-packet counter.

Ports:
r_clk  in  1  read-domain clock; all state on rising edge.
rrst  in  1  synchronous reset, active-high.
fifo_empty  in  1  FIFO empty flag (read domain).
fifo_dout  in  DATA_W  FIFO D_out; valid the cycle after an accepted pop.
fifo_r_en  out  1  pop request to FIFO r_en.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accept.
m_data  out  DATA_W  output word.
m_last  out  1  final beat of packet; qualified by m_valid.
pkt_cnt  out  CNT_W  completed packets, wraps modulo 2^CNT_W.

Behaviour:
- Interface: one clock (r_clk); reset rrst is synchronous and active-high.
- Reset values (cycle after rrst is sampled high):
  - m_valid=0, m_last=0, m_data=0, pkt_cnt=0.
  - Buffer occupancy occ=0, rd_pend=0, beat index=0.
- fifo_r_en is forced 0 while rrst=1.
- FIFO read model:
  - A pop is accepted when fifo_r_en=1 and fifo_empty=0.
  - The word appears on fifo_dout on the next cycle.
  - rd_pend is a 1-bit register that records "pop accepted last cycle".
- Pop issue rule (combinational):
  - pop = m_valid & m_ready.
  - fifo_r_en = !rrst & !fifo_empty & ((occ + rd_pend - pop) < 2).
  - This guarantees buffer space for every in-flight word.
  - It also sustains 1 word/cycle when m_ready stays high.
- Capture:
  - When rd_pend=1, fifo_dout is written to the buffer tail that cycle.
  - Simultaneous capture and pop: occ is unchanged; the head advances and the new word goes behind the remaining entry, or to the head if occ was 1.
- Buffer overflow (occ=2 with rd_pend=1 and no pop) is impossible by construction.
  - Add an assertion for it.
- Output rules:
  - m_valid = (occ != 0).
  - m_data is the buffer head.
  - m_data and m_last are stable while m_valid & !m_ready.
- Latency:
  - FIFO non-empty with idle buffer: fifo_r_en is asserted in cycle T, and m_valid is high in T+2.
  - Back-to-back words follow at 1/cycle.
- Framing:
  - Beat index is 0..PKT_LEN-1 and increments on each handshake (pop).
  - m_last = m_valid & (beat == PKT_LEN-1).
  - A handshake with m_last wraps beat to 0 and increments pkt_cnt (wraps 2^CNT_W-1 → 0).
  - PKT_LEN=1: m_last=m_valid on every beat.
- FIFO empty mid-packet: no framing reset; beat holds and m_valid drops once the buffer drains.
- Reset mid-operation:
  - A word in flight (rd_pend=1) is discarded.
  - Buffer contents are discarded; beat and pkt_cnt clear.
  - No FIFO pop is issued in the reset cycle.
- No combinational path from fifo_dout to any output.
- The only combinational input→output path is m_ready/fifo_empty → fifo_r_en.

Decomposition:
- Shared package: DATA_W default, and a constant for buffer depth (2) with its occupancy width (2 bits).
- One natural sub-module: stream_skid_buf, a 2-entry register FIFO providing occ, head data, wr, and rd.
- fifo_rd_stream holds the pop-issue logic, rd_pend, beat counter and pkt_cnt.

Test Plan:
- Reset then idle (fifo_empty=1) → fifo_r_en=0, m_valid=0, pkt_cnt=0 for 20 cycles.
- Preload 8 words 0x0001..0x0008, m_ready=1 → fifo_r_en high 8 consecutive cycles.
  - m_valid high 8 consecutive cycles starting 2 after first pop; data 0x0001..0x0008 in order.
  - m_last only on 0x0008; pkt_cnt=1.
- Preload 16 words, hold m_ready=0 → exactly 2 pops issued, m_valid=1, m_data=0x0001 stable.
  - Release m_ready → remaining 14 pops follow, all 16 delivered in order.
  - Two m_last pulses; pkt_cnt=2.
- Random m_ready (50%) with 3 words then empty for 10 cycles, then 5 more.
  - Exactly 8 beats delivered; m_last on the 8th; no pop while fifo_empty=1.
- Assert rrst the cycle after a pop with 1 word buffered → next cycle m_valid=0, pkt_cnt=0, beat=0.
  - The next delivered word is the following FIFO entry, with no duplicate.
- PKT_LEN=1, CNT_W=8, 260 words streamed → m_last on every beat; pkt_cnt wraps to 4.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side drain stage: default word width and
// skid-buffer geometry.
package fifo_rd_stream_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int BUF_DEPTH  = 2;
  localparam int OCC_W      = 2;

  typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO holding words already popped from the async FIFO.
// Head is presented directly; a simultaneous write and read keeps occupancy.
module stream_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output occ_t              occ_o,
  output logic [DATA_W-1:0] head_o
);

  occ_t              occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({wr_i, rd_i})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = wdata_i;
        else               tail_d = wdata_i;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        // Read and write together: the new word lands behind whatever remains.
        if (occ_q == OCC_W'(BUF_DEPTH)) begin
          head_d = tail_q;
          tail_d = wdata_i;
        end else begin
          head_d = wdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      head_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign occ_o  = occ_q;
  assign head_o = head_q;

  ovf_chk: assert property (@(posedge clk) disable iff (rst)
    !(wr_i && !rd_i && occ_q == OCC_W'(BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream with fixed-length
// packet framing and a wrapping completed-packet counter.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic              r_clk,
  input  logic              rrst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  occ_t              occ;
  logic              pop;
  logic              rd_pend_q, rd_pend_d;
  logic [OCC_W:0]    inflight;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;

  assign pop = m_valid & m_ready;

  // Words buffered plus the one in flight, after this cycle's handshake: a pop
  // is only issued when that leaves a free slot for the returning word.
  assign inflight  = {1'b0, occ} + {{OCC_W{1'b0}}, rd_pend_q} - {{OCC_W{1'b0}}, pop};
  assign fifo_r_en = !rrst && !fifo_empty && (inflight < (OCC_W+1)'(BUF_DEPTH));
  assign rd_pend_d = fifo_r_en;

  stream_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (r_clk),
    .rst     (rrst),
    .wr_i    (rd_pend_q),
    .wdata_i (fifo_dout),
    .rd_i    (pop),
    .occ_o   (occ),
    .head_o  (m_data)
  );

  assign m_valid = (occ != '0);
  assign m_last  = m_valid && (beat_q == LAST_BEAT);

  always_comb begin
    beat_d = beat_q;
    pkt_d  = pkt_q;
    if (pop) begin
      if (beat_q == LAST_BEAT) begin
        beat_d = '0;
        pkt_d  = pkt_q + 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge r_clk) begin
    if (rrst) begin
      rd_pend_q <= 1'b0;
      beat_q    <= '0;
      pkt_q     <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      beat_q    <= beat_d;
      pkt_q     <= pkt_d;
    end
  end

  assign pkt_cnt = pkt_q;

endmodule
